// File: rtl/obstacle_spawner_if.sv
// Handshake bundle between the game control, the spawn scheduler and the cactus object.
// The master drives frame/enable/active and the slave answers with the spawn request.
interface obstacle_spawner_if;
  logic       next_frame_i;
  logic       enable_i;
  logic       obstacle_active_i;
  logic       spawn_o;
  logic [1:0] rand_o;
  logic [7:0] spawn_count_o;

  modport master (
    output next_frame_i, enable_i, obstacle_active_i,
    input  spawn_o, rand_o, spawn_count_o
  );

  modport slave (
    input  next_frame_i, enable_i, obstacle_active_i,
    output spawn_o, rand_o, spawn_count_o
  );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawn scheduler: a free-running LFSR picks a randomized frame gap, after which
// a spawn request with a stable variant is held until the obstacle reports it went active.
module obstacle_spawner #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          MIN_GAP        = 30,
  parameter int          GAP_RANGE_LOG2 = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obstacle_spawner_if.slave   bus
);

  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  EXTRA_MASK = 8'((1 << GAP_RANGE_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [9:0]  gap_q, gap_d;
  logic [1:0]  rand_q, rand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        spawn_q, spawn_d;
  logic        active_prev_q;
  logic        ack;
  logic [9:0]  gap_load;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Masking the low byte keeps a zero-width random range legal (extra is then always 0).
  assign gap_load = 10'(MIN_GAP) + {2'b00, lfsr_q[7:0] & EXTRA_MASK};
  assign ack      = bus.obstacle_active_i & ~active_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q        <= SEED_EFF;
      active_prev_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_step(lfsr_q);
      active_prev_q <= bus.obstacle_active_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= '0;
      rand_q  <= '0;
      cnt_q   <= '0;
      spawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rand_q  <= rand_d;
      cnt_q   <= cnt_d;
      spawn_q <= spawn_d;
    end
  end

  // Disable dominates any acknowledge or frame pulse arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rand_d  = rand_q;
    cnt_d   = cnt_q;
    if (!bus.enable_i) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gap_d   = gap_load;
          state_d = GAP;
        end
        GAP: begin
          if (gap_q == 10'd0) begin
            state_d = ARMED;
            rand_d  = lfsr_q[1:0];
          end else if (bus.next_frame_i) begin
            gap_d = gap_q - 10'd1;
          end
        end
        ARMED: begin
          if (ack) begin
            cnt_d   = cnt_q + 8'd1;
            gap_d   = gap_load;
            state_d = GAP;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase
    end
    spawn_d = (state_d == ARMED);
  end

  assign bus.spawn_o       = spawn_q;
  assign bus.rand_o        = rand_q;
  assign bus.spawn_count_o = cnt_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: three instances cover default, fixed-gap-3 and zero-gap setups.
module tb_obstacle_spawner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr, m_prev;
  logic [1:0] exp_rand;

  always #5 clk = ~clk;

  obstacle_spawner_if if_def ();
  obstacle_spawner_if if_g3 ();
  obstacle_spawner_if if_g0 ();

  obstacle_spawner u_def (.clk_i(clk), .rst_ni(rst_n), .bus(if_def));
  obstacle_spawner #(.MIN_GAP(3), .GAP_RANGE_LOG2(0)) u_g3 (.clk_i(clk), .rst_ni(rst_n), .bus(if_g3));
  obstacle_spawner #(.MIN_GAP(0), .GAP_RANGE_LOG2(0)) u_g0 (.clk_i(clk), .rst_ni(rst_n), .bus(if_g0));

  // Reference LFSR; m_prev is the value the DUT saw in the cycle before the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      m_prev <= m_lfsr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {if_def.next_frame_i, if_def.enable_i, if_def.obstacle_active_i} = 3'b000;
    {if_g3.next_frame_i, if_g3.enable_i, if_g3.obstacle_active_i} = 3'b000;
    {if_g0.next_frame_i, if_g0.enable_i, if_g0.obstacle_active_i} = 3'b000;
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (if_def.spawn_o !== 1'b0) begin fails++; $display("FAIL reset_spawn got %0b exp 0", if_def.spawn_o); end
    tests++; if (if_def.rand_o !== 2'd0) begin fails++; $display("FAIL reset_rand got %0d exp 0", if_def.rand_o); end
    tests++; if (if_def.spawn_count_o !== 8'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", if_def.spawn_count_o); end
    tests++; if (u_def.lfsr_q !== 16'hACE1) begin fails++; $display("FAIL reset_lfsr got %h exp ace1", u_def.lfsr_q); end
    rst_n = 1'b1;
    tick(); tick();
    tests++; if (u_def.lfsr_q !== 16'hAB38) begin fails++; $display("FAIL lfsr_2clk got %h exp ab38", u_def.lfsr_q); end
  endtask

  task automatic test_default_gap();
    int exp_gap;
    int pulses;
    if_def.enable_i = 1'b1;
    tick();
    exp_gap = 30 + int'(m_prev[5:0]);
    if_def.enable_i = 1'b1;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      if (if_def.spawn_o) break;
      if_def.next_frame_i = 1'b1; tick();
      if_def.next_frame_i = 1'b0; pulses++; tick();
    end
    tests++; if (if_def.spawn_o !== 1'b1) begin fails++; $display("FAIL default_gap_timeout spawn %0b exp 1", if_def.spawn_o); end
    tests++; if (pulses != exp_gap) begin fails++; $display("FAIL default_gap_len got %0d exp %0d", pulses, exp_gap); end
  endtask

  task automatic test_gap_latency();
    if_g3.obstacle_active_i = 1'b1;
    tick();
    if_g3.enable_i = 1'b1;
    tick();
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL lat_after_enable got %0b exp 0", if_g3.spawn_o); end
    for (int i = 0; i < 2; i++) begin
      if_g3.next_frame_i = 1'b1; tick();
      if_g3.next_frame_i = 1'b0; tick();
    end
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL lat_after_2 got %0b exp 0", if_g3.spawn_o); end
    if_g3.next_frame_i = 1'b1; tick();
    if_g3.next_frame_i = 1'b0;
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL lat_at_3rd got %0b exp 0", if_g3.spawn_o); end
    tick();
    exp_rand = m_prev[1:0];
    tests++; if (if_g3.spawn_o !== 1'b1) begin fails++; $display("FAIL lat_rise got %0b exp 1", if_g3.spawn_o); end
    tests++; if (if_g3.rand_o !== exp_rand) begin fails++; $display("FAIL rand_latch got %0d exp %0d", if_g3.rand_o, exp_rand); end
  endtask

  task automatic test_already_active();
    int bad_spawn, bad_cnt, bad_rand;
    bad_spawn = 0; bad_cnt = 0; bad_rand = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (if_g3.spawn_o !== 1'b1) bad_spawn++;
      if (if_g3.spawn_count_o !== 8'd0) bad_cnt++;
      if (if_g3.rand_o !== exp_rand) bad_rand++;
    end
    tests++; if (bad_spawn != 0) begin fails++; $display("FAIL held_spawn bad cycles %0d exp 0", bad_spawn); end
    tests++; if (bad_cnt != 0) begin fails++; $display("FAIL held_count bad cycles %0d exp 0", bad_cnt); end
    tests++; if (bad_rand != 0) begin fails++; $display("FAIL rand_stable bad cycles %0d exp 0", bad_rand); end
    if_g3.obstacle_active_i = 1'b0; tick();
    tests++; if (if_g3.spawn_o !== 1'b1) begin fails++; $display("FAIL spawn_after_fall got %0b exp 1", if_g3.spawn_o); end
    if_g3.obstacle_active_i = 1'b1;
    if_g3.next_frame_i = 1'b1;
    tick();
    if_g3.next_frame_i = 1'b0;
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL ack_drop got %0b exp 0", if_g3.spawn_o); end
    tests++; if (if_g3.spawn_count_o !== 8'd1) begin fails++; $display("FAIL ack_count got %0d exp 1", if_g3.spawn_count_o); end
  endtask

  task automatic test_ack_with_frame();
    for (int i = 0; i < 2; i++) begin
      if_g3.next_frame_i = 1'b1; tick();
      if_g3.next_frame_i = 1'b0; tick();
    end
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL ackframe_early got %0b exp 0", if_g3.spawn_o); end
    if_g3.next_frame_i = 1'b1; tick();
    if_g3.next_frame_i = 1'b0; tick();
    tests++; if (if_g3.spawn_o !== 1'b1) begin fails++; $display("FAIL ackframe_rise got %0b exp 1", if_g3.spawn_o); end
  endtask

  task automatic test_disable();
    exp_rand = if_g3.rand_o;
    if_g3.obstacle_active_i = 1'b0; tick();
    if_g3.obstacle_active_i = 1'b1;
    if_g3.enable_i = 1'b0;
    tick();
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL dis_armed_spawn got %0b exp 0", if_g3.spawn_o); end
    tests++; if (if_g3.spawn_count_o !== 8'd1) begin fails++; $display("FAIL dis_ack_count got %0d exp 1", if_g3.spawn_count_o); end
    tests++; if (if_g3.rand_o !== exp_rand) begin fails++; $display("FAIL dis_rand_hold got %0d exp %0d", if_g3.rand_o, exp_rand); end
    if_g3.enable_i = 1'b1; tick();
    if_g3.next_frame_i = 1'b1; tick();
    if_g3.enable_i = 1'b0; tick();
    if_g3.next_frame_i = 1'b0;
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL dis_gap_spawn got %0b exp 0", if_g3.spawn_o); end
    if_g3.enable_i = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      if_g3.next_frame_i = 1'b1; tick();
      if_g3.next_frame_i = 1'b0; tick();
    end
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL reenable_full_gap got %0b exp 0", if_g3.spawn_o); end
    if_g3.next_frame_i = 1'b1; tick();
    if_g3.next_frame_i = 1'b0; tick();
    tests++; if (if_g3.spawn_o !== 1'b1) begin fails++; $display("FAIL reenable_rise got %0b exp 1", if_g3.spawn_o); end
    tests++; if (if_g3.spawn_count_o !== 8'd1) begin fails++; $display("FAIL reenable_count got %0d exp 1", if_g3.spawn_count_o); end
  endtask

  task automatic test_load_zero_and_wrap();
    int timeouts;
    timeouts = 0;
    if_g0.enable_i = 1'b1;
    tick();
    tests++; if (if_g0.spawn_o !== 1'b0) begin fails++; $display("FAIL zero_load_1cyc got %0b exp 0", if_g0.spawn_o); end
    tick();
    tests++; if (if_g0.spawn_o !== 1'b1) begin fails++; $display("FAIL zero_load_2cyc got %0b exp 1", if_g0.spawn_o); end
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < 5 && !if_g0.spawn_o; w++) tick();
      if (!if_g0.spawn_o) timeouts++;
      if_g0.obstacle_active_i = 1'b1; tick();
      if_g0.obstacle_active_i = 1'b0;
      if (i == 0) begin
        tests++; if (if_g0.spawn_count_o !== 8'd1) begin fails++; $display("FAIL wrap_first got %0d exp 1", if_g0.spawn_count_o); end
      end
      if (i == 254) begin
        tests++; if (if_g0.spawn_count_o !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d exp 255", if_g0.spawn_count_o); end
      end
    end
    tests++; if (timeouts != 0) begin fails++; $display("FAIL wrap_timeouts got %0d exp 0", timeouts); end
    tests++; if (if_g0.spawn_count_o !== 8'd0) begin fails++; $display("FAIL wrap_zero got %0d exp 0", if_g0.spawn_count_o); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (if_g3.spawn_o !== 1'b0) begin fails++; $display("FAIL async_spawn got %0b exp 0", if_g3.spawn_o); end
    tests++; if (if_g3.spawn_count_o !== 8'd0) begin fails++; $display("FAIL async_count got %0d exp 0", if_g3.spawn_count_o); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_default_gap();
    test_gap_latency();
    test_already_active();
    test_ack_with_frame();
    test_disable();
    test_load_zero_and_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached exp finish");
    $fatal(1);
  end
endmodule
